imem_load_controller: RTL and testbench

- Sequences UART-based program loading into the 16-bit instruction memory.
- Takes received bytes from the UART receiver (valid strobe plus byte) and parses a framed image: sync byte, word count, high/low byte pairs, XOR checksum.
- Drives the instruction memory write port and holds the CPU in reset until a valid image is loaded.
- Sits between the UART receiver, the instruction memory and the CPU's reset/run logic.

---
 rtl/brisc_pkg.sv | 24 ++
 rtl/imem_load_timeout.sv | 33 +++
 rtl/imem_load_controller.sv | 187 ++++++++++++++++++
 tb/tb_imem_load_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - load_state_e   : loader FSM state encoding
//   - INSTR_W        : instruction word width
//   - DEFAULT_DEPTH / DEFAULT_ADDR_W : default instruction memory geometry
//   - DEFAULT_SYNC_BYTE : default frame start marker
package brisc_pkg;

  localparam int INSTR_W        = 16;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_ADDR_W = 5;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } load_state_e;

endpackage

// File: rtl/imem_load_timeout.sv
// Inter-byte idle counter for the loader.
//   CLK     : clock
//   RST     : synchronous active-high reset
//   clear   : force the count to zero (has priority over enable)
//   enable  : count one idle cycle
//   expired : high on the idle cycle that brings the count to TIMEOUT_CYCLES
module imem_load_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flag the cycle whose increment would land on TIMEOUT_CYCLES, so the
  // controller leaves the frame on the same edge the count gets there.
  assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/imem_load_controller.sv
// UART program loader for the 16-bit instruction memory.
// Frame: SYNC_BYTE, word count (1..DEPTH), {high, low} byte per word,
// XOR of all data bytes. The CPU is held until a frame checks out.
//
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   rx_valid      : one-cycle strobe, rx_data holds a new byte
//   rx_data       : received byte
//   reload_req    : abort and return to IDLE (wins over rx_valid)
//   mem_we        : one-cycle write pulse per word
//   mem_waddr     : write address
//   mem_wdata     : write data {high, low}
//   load_done     : valid image loaded
//   load_error    : last frame failed (length, checksum, timeout)
//   cpu_hold      : ~load_done, registered alongside it
//   words_loaded  : words written in the current or last frame
//   state_dbg     : current FSM state
//
// Handshake: rx_valid is a pure strobe with no back-pressure; every byte
// presented with rx_valid=1 is consumed in that cycle or deliberately dropped.
module imem_load_controller
  import brisc_pkg::*;
#(
  parameter int         DEPTH          = DEFAULT_DEPTH,
  parameter int         ADDR_W         = DEFAULT_ADDR_W,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               reload_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               load_done,
  output logic               load_error,
  output logic               cpu_hold,
  output logic [ADDR_W:0]    words_loaded,
  output load_state_e        state_dbg
);

  localparam logic [ADDR_W:0]   ONE_W = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  load_state_e        state, state_n;
  logic [ADDR_W:0]    len, len_n;
  logic [7:0]         xor_acc, xor_n;
  logic [7:0]         hi_byte, hi_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [ADDR_W:0]    words_n;
  logic               we_n;
  logic [ADDR_W-1:0]  waddr_n;
  logic [INSTR_W-1:0] wdata_n;
  logic               done_n;
  logic               err_n;

  logic in_frame;
  logic len_ok;
  logic timed_out;

  assign in_frame  = (state == ST_LEN) || (state == ST_HI) ||
                     (state == ST_LO)  || (state == ST_CHK);
  assign len_ok    = (rx_data != 8'd0) && (int'(rx_data) <= DEPTH);
  assign state_dbg = state;

  imem_load_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (rx_valid || !in_frame),
    .enable (in_frame && !rx_valid),
    .expired(timed_out)
  );

  always_comb begin
    state_n = state;
    len_n   = len;
    xor_n   = xor_acc;
    hi_n    = hi_byte;
    addr_n  = addr;
    words_n = words_loaded;
    we_n    = 1'b0;
    waddr_n = mem_waddr;
    wdata_n = mem_wdata;
    done_n  = load_done;
    err_n   = load_error;

    if (reload_req) begin
      // Any byte arriving with the reload is dropped.
      state_n = ST_IDLE;
      done_n  = 1'b0;
      err_n   = 1'b0;
      words_n = '0;
    end else if (timed_out) begin
      state_n = ST_ERR;
      done_n  = 1'b0;
      err_n   = 1'b1;
    end else if (rx_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) state_n = ST_LEN;
        end
        ST_LEN: begin
          if (len_ok) begin
            len_n   = rx_data[ADDR_W:0];
            xor_n   = 8'd0;
            words_n = '0;
            addr_n  = '0;
            state_n = ST_HI;
          end else begin
            state_n = ST_ERR;
            done_n  = 1'b0;
            err_n   = 1'b1;
          end
        end
        ST_HI: begin
          hi_n    = rx_data;
          xor_n   = xor_acc ^ rx_data;
          state_n = ST_LO;
        end
        ST_LO: begin
          we_n    = 1'b1;
          waddr_n = addr;
          wdata_n = {hi_byte, rx_data};
          xor_n   = xor_acc ^ rx_data;
          addr_n  = addr + ONE_A;
          words_n = words_loaded + ONE_W;
          state_n = ((words_loaded + ONE_W) == len) ? ST_CHK : ST_HI;
        end
        ST_CHK: begin
          if (rx_data == xor_acc) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_ERR;
            done_n  = 1'b0;
            err_n   = 1'b1;
          end
        end
        ST_DONE: begin
          // Image is live; stray bytes must not disturb memory.
        end
        ST_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            state_n = ST_LEN;
            err_n   = 1'b0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      len          <= '0;
      xor_acc      <= 8'd0;
      hi_byte      <= 8'd0;
      addr         <= '0;
      words_loaded <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      cpu_hold     <= 1'b1;
    end else begin
      state        <= state_n;
      len          <= len_n;
      xor_acc      <= xor_n;
      hi_byte      <= hi_n;
      addr         <= addr_n;
      words_loaded <= words_n;
      mem_we       <= we_n;
      mem_waddr    <= waddr_n;
      mem_wdata    <= wdata_n;
      load_done    <= done_n;
      load_error   <= err_n;
      cpu_hold     <= ~done_n;
    end
  end

endmodule

// File: tb/tb_imem_load_controller.sv
// Bench for imem_load_controller: constant frame table, hand-written
// timeout / reload / reset sequences, then random frames scored against a
// frame-level model (writes, flags, memory image).
module tb_imem_load_controller;
  import brisc_pkg::*;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int TMO    = 16;
  localparam int WR_W   = ADDR_W + 16;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    bit          reload;
    int          n;
    logic [63:0] bytes;    // byte 0 in bits 63:56
    logic [7:0]  we_mask;  // bit j: byte j produces a write next cycle
    int          nw;
    logic [WR_W-1:0] w0;
    logic [WR_W-1:0] w1;
    bit          done;
    bit          err;
    int          words;
  } vec_t;

  logic              CLK;
  logic              RST;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              reload_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic              load_done;
  logic              load_error;
  logic              cpu_hold;
  logic [ADDR_W:0]   words_loaded;
  load_state_e       state_dbg;

  imem_load_controller #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
  ) dut (
    .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data),
    .reload_req(reload_req), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .load_done(load_done), .load_error(load_error),
    .cpu_hold(cpu_hold), .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [WR_W-1:0] exp_q[$];
  logic [15:0] dut_mem[DEPTH];
  logic [15:0] model_mem[DEPTH];
  bit m_done;
  bit m_err;
  int m_words;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [WR_W-1:0] mon_e;
  always @(negedge CLK) begin
    if (mem_we === 1'b1) begin
      dut_mem[mem_waddr] = mem_wdata;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", mem_waddr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", {11'd0, mem_waddr, mem_wdata}, {11'd0, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_write(input int a, input logic [15:0] d);
    exp_q.push_back({a[ADDR_W-1:0], d});
    model_mem[a] = d;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_we);
    @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge CLK);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    check("we_latency", {31'd0, mem_we}, {31'd0, exp_we});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_reload();
    @(negedge CLK);
    reload_req = 1'b1;
    @(negedge CLK);
    reload_req = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_words = 0;
  endtask

  task automatic check_flags(input string name, input bit d, input bit e, input int w);
    check({name, "_done"},  {31'd0, load_done},  {31'd0, d});
    check({name, "_error"}, {31'd0, load_error}, {31'd0, e});
    check({name, "_hold"},  {31'd0, cpu_hold},   {31'd0, ~d});
    check({name, "_words"}, {26'd0, words_loaded}, w);
  endtask

  // Frame-level reference: derives writes and outcome from the frame rules.
  task automatic run_frame(input bq_t fb);
    int lenv;
    bit ok;
    bit complete;
    bit we;
    int nw;
    logic [7:0] x;
    lenv = int'(fb[1]);
    ok   = (lenv >= 1) && (lenv <= DEPTH);
    nw   = 0;
    x    = 8'd0;
    for (int i = 0; i < fb.size(); i++) begin
      we = 1'b0;
      if (ok && i >= 2 && i < 2 + 2 * lenv) begin
        x ^= fb[i];
        if ((i % 2) == 1) begin
          push_write((i - 3) / 2, {fb[i-1], fb[i]});
          we = 1'b1;
          nw++;
        end
      end
      send_byte(fb[i], we);
      if (i != fb.size() - 1) idle($urandom_range(0, 3));
    end
    complete = ok && (fb.size() == 3 + 2 * lenv);
    if (!ok) begin
      m_done = 1'b0;
      m_err  = 1'b1;
    end else if (!complete) begin
      idle(TMO + 4);
      m_done  = 1'b0;
      m_err   = 1'b1;
      m_words = nw;
    end else begin
      m_words = nw;
      m_done  = (fb[fb.size()-1] == x);
      m_err   = !m_done;
    end
    check_flags("rnd", m_done, m_err, m_words);
  endtask

  vec_t vt[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t fb;
    int kind;
    int len;
    int k;
    logic [7:0] x;

    for (int i = 0; i < DEPTH; i++) begin
      dut_mem[i]   = 16'h0;
      model_mem[i] = 16'h0;
    end

    vt[0] = '{reload: 1'b0, n: 7, bytes: 64'hA5_02_10_50_11_4E_1F_00, we_mask: 8'b0010_1000,
              nw: 2, w0: {5'd0, 16'h1050}, w1: {5'd1, 16'h114E}, done: 1'b1, err: 1'b0, words: 2};
    vt[1] = '{reload: 1'b1, n: 7, bytes: 64'hA5_02_10_50_11_4E_0E_00, we_mask: 8'b0010_1000,
              nw: 2, w0: {5'd0, 16'h1050}, w1: {5'd1, 16'h114E}, done: 1'b0, err: 1'b1, words: 2};
    vt[2] = '{reload: 1'b0, n: 5, bytes: 64'hA5_01_F8_04_00_00_00_00, we_mask: 8'b0000_1000,
              nw: 1, w0: {5'd0, 16'hF804}, w1: '0, done: 1'b0, err: 1'b1, words: 1};
    vt[3] = '{reload: 1'b0, n: 2, bytes: 64'hA5_00_00_00_00_00_00_00, we_mask: 8'b0,
              nw: 0, w0: '0, w1: '0, done: 1'b0, err: 1'b1, words: 1};
    vt[4] = '{reload: 1'b0, n: 2, bytes: 64'hA5_21_00_00_00_00_00_00, we_mask: 8'b0,
              nw: 0, w0: '0, w1: '0, done: 1'b0, err: 1'b1, words: 1};
    vt[5] = '{reload: 1'b0, n: 5, bytes: 64'hA5_01_D0_00_D0_00_00_00, we_mask: 8'b0000_1000,
              nw: 1, w0: {5'd0, 16'hD000}, w1: '0, done: 1'b1, err: 1'b0, words: 1};

    RST        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    reload_req = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_we",    {31'd0, mem_we}, 32'd0);
    check("rst_waddr", {27'd0, mem_waddr}, 32'd0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check_flags("rst", 1'b0, 1'b0, 0);
    RST = 1'b0;

    // Table of whole frames
    for (int i = 0; i < 6; i++) begin
      if (vt[i].reload) pulse_reload();
      if (vt[i].nw > 0) push_write(int'(vt[i].w0[WR_W-1:16]), vt[i].w0[15:0]);
      if (vt[i].nw > 1) push_write(int'(vt[i].w1[WR_W-1:16]), vt[i].w1[15:0]);
      for (int j = 0; j < vt[i].n; j++) begin
        send_byte(vt[i].bytes[63 - 8 * j -: 8], vt[i].we_mask[j]);
      end
      check_flags($sformatf("vec%0d", i), vt[i].done, vt[i].err, vt[i].words);
      check($sformatf("vec%0d_pending", i), exp_q.size(), 32'd0);
    end

    // Timeout: 16 idle cycles inside a frame errors out, 15 does not
    pulse_reload();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hF5, 1'b0);
    idle(TMO - 1);
    check("tmo_before_err", {31'd0, load_error}, 32'd0);
    check("tmo_before_state", {29'd0, state_dbg}, {29'd0, ST_LO});
    idle(1);
    check("tmo_at_err", {31'd0, load_error}, 32'd1);
    check("tmo_at_state", {29'd0, state_dbg}, {29'd0, ST_ERR});
    check_flags("tmo", 1'b0, 1'b1, 0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hF5, 1'b0);
    idle(TMO - 2);
    push_write(0, 16'hF501);
    send_byte(8'h01, 1'b1);
    idle(TMO - 2);
    send_byte(8'hF4, 1'b0);
    check_flags("tmo_ok", 1'b1, 1'b0, 1);

    // Reload coincident with a sync byte: byte is dropped
    @(negedge CLK);
    reload_req = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = 8'hA5;
    @(negedge CLK);
    reload_req = 1'b0;
    rx_valid   = 1'b0;
    check("reload_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check_flags("reload", 1'b0, 1'b0, 0);
    push_write(0, 16'h1234);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    send_byte(8'h26, 1'b0);
    check_flags("reload_frame", 1'b1, 1'b0, 1);

    // Reset in the middle of a frame
    pulse_reload();
    push_write(0, 16'h3144);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h31, 1'b0);
    send_byte(8'h44, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mrst_we",    {31'd0, mem_we}, 32'd0);
    check("mrst_waddr", {27'd0, mem_waddr}, 32'd0);
    check("mrst_wdata", {16'd0, mem_wdata}, 32'd0);
    check("mrst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check_flags("mrst", 1'b0, 1'b0, 0);
    push_write(0, 16'hABCD);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h66, 1'b0);
    check_flags("mrst_frame", 1'b1, 1'b0, 1);

    // Random frames against the frame-level model
    m_done  = 1'b1;
    m_err   = 1'b0;
    m_words = 1;
    for (int f = 0; f < 30; f++) begin
      if (m_done) begin
        pulse_reload();
        check_flags("rnd_reload", 1'b0, 1'b0, 0);
      end
      kind = (f == 0) ? 5 : $urandom_range(0, 9);
      len  = (f == 0) ? DEPTH : $urandom_range(1, DEPTH);
      fb = {};
      fb.push_back(8'hA5);
      if (kind == 0) begin
        fb.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(DEPTH + 1, 255)));
      end else begin
        fb.push_back(8'(len));
        x = 8'h00;
        for (int j = 0; j < 2 * len; j++) begin
          fb.push_back(8'($urandom));
          x ^= fb[fb.size()-1];
        end
        if (kind == 1) x ^= 8'($urandom_range(1, 255));
        fb.push_back(x);
        if (kind == 2) begin
          k = $urandom_range(2, 2 + 2 * len);
          while (fb.size() > k) void'(fb.pop_back());
        end
      end
      run_frame(fb);
    end

    idle(2);
    check("final_pending", exp_q.size(), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("mem%0d", i), {16'd0, dut_mem[i]}, {16'd0, model_mem[i]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
